regfile_write_arbiter: RTL

- Shares the single write port of the 32x32 register file between two writeback requesters: requester 0 (ALU writeback) and requester 1 (load/memory writeback).
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Drives registered wrenable/address/data into the register file.
- Writes to register 0 are accepted but suppressed, because register 0 is hardwired to zero.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 51 +++++
 rtl/regfile_write_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter and its
// reusable 2-way round-robin arbiter.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // Index of a requester on a 2-way shared port.
    typedef logic req_idx_t;

    // Round-robin preference: the requester that was not served last.
    function automatic req_idx_t rr_other(input req_idx_t idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a last-grant flop.
// Grants are combinational from the valids, the stall input and the last
// grant, so a requester sees ready in the same cycle it asserts valid.
// Reset is synchronous and active-low; grants are forced off while it is low.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] valid_i,
    input  logic       stall_i,
    output logic [1:0] grant_o,
    output req_idx_t   last_grant_o
);

    req_idx_t last_q;
    req_idx_t last_d;

    // Grant selection: a lone valid wins; on contention the one not served last.
    always_comb begin
        grant_o = 2'b00;
        if (reset_n && !stall_i) begin
            unique case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = (rr_other(last_q) == 1'b1) ? 2'b10 : 2'b01;
                default: grant_o = 2'b00;
            endcase
        end
    end

    // Last-grant next state: move only when someone is actually granted.
    always_comb begin
        last_d = last_q;
        if (grant_o != 2'b00) begin
            last_d = grant_o[1];
        end
    end

    // Last-grant register; resets to 1 so requester 0 wins the first contest.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_grant_o = last_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between the ALU writeback
// (requester 0) and the load writeback (requester 1). The write is registered:
// a grant on one edge becomes a write-enable pulse in the following cycle.
// Writes to register 0 complete their handshake but never reach the file.
// Optional statistics counters: define REGFILE_WRITE_ARBITER_STATS_EN.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              rf_stall,
    output logic              rf_wrenable,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              last_grant
`ifdef REGFILE_WRITE_ARBITER_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant0_count,
    output logic [CNT_W-1:0]  grant1_count,
    output logic [CNT_W-1:0]  zero_drop_count
`endif
);

    logic [1:0]        grant;
    req_idx_t          last_idx;
    logic              granted;
    logic              zero_hit;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    rr_arbiter2 u_arb (
        .clk          (clk),
        .reset_n      (reset_n),
        .valid_i      ({req1_valid, req0_valid}),
        .stall_i      (rf_stall),
        .grant_o      (grant),
        .last_grant_o (last_idx)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign last_grant = last_idx;

    // Steer the granted request into the output stage; a register-0 grant
    // and an idle cycle both leave address/data holding their old values.
    always_comb begin
        granted  = (grant != 2'b00);
        sel_addr = grant[1] ? req1_addr : req0_addr;
        sel_data = grant[1] ? req1_data : req0_data;
        zero_hit = granted && (sel_addr == ADDR_W'(ZERO_REG));
        wren_d   = granted && !zero_hit;
        addr_d   = wren_d ? sel_addr : addr_q;
        data_d   = wren_d ? sel_data : data_q;
    end

    // Registered write port; reset drops any write still in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wren_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wren_q <= wren_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign rf_wrenable = wren_q;
    assign rf_addr     = addr_q;
    assign rf_data     = data_q;

`ifdef REGFILE_WRITE_ARBITER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] g0_cnt_q, g1_cnt_q, zd_cnt_q;

    // Saturating grant and register-0 drop counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            g0_cnt_q <= '0;
            g1_cnt_q <= '0;
            zd_cnt_q <= '0;
        end else begin
            if (grant[0] && g0_cnt_q != CNT_MAX) g0_cnt_q <= g0_cnt_q + 1'b1;
            if (grant[1] && g1_cnt_q != CNT_MAX) g1_cnt_q <= g1_cnt_q + 1'b1;
            if (zero_hit && zd_cnt_q != CNT_MAX) zd_cnt_q <= zd_cnt_q + 1'b1;
        end
    end

    assign grant0_count    = g0_cnt_q;
    assign grant1_count    = g1_cnt_q;
    assign zero_drop_count = zd_cnt_q;
`endif

endmodule
